// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: FSM states,
// opcode/funct constants, ALU control codes and datapath mux selects.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Bit 2 negates B, bits [1:0] pick and/or/add/slt.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and the
// shared-ALU datapath plus unified memory (slave).
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst,
           memtoreg, alusrca, alusrcb, pcsrc, alucontrol, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst,
           memtoreg, alusrca, alusrcb, pcsrc, alucontrol, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU control decoder: maps the FSM's aluop and the R-type funct field to the
// 3-bit ALU code, flagging funct values the datapath does not implement.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  aluop_e     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned; otherwise synthesis infers a latch.
  always_comb begin
    alucontrol    = ALU_ADD;
    funct_illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: Moore FSM sequencing fetch, decode,
// execute and writeback, stalling on the memory ready handshake.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus,
  output logic [STATE_W-1:0] state
);

  state_e     state_q, state_d;
  aluop_e     aluop;
  logic [2:0] alu_code;
  logic       funct_illegal;

  logic       mem_req_raw, memwrite_raw, irwrite_raw, illegal_raw;
  logic       pcwrite, branch;
  logic       iord, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;

  alu_decoder u_alu_decoder (
    .aluop         (aluop),
    .funct         (bus.funct),
    .alucontrol    (alu_code),
    .funct_illegal (funct_illegal)
  );

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    aluop        = ALUOP_ADD;
    mem_req_raw  = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    illegal_raw  = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    regwrite     = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_B;
    pcsrc        = PCSRC_ALU;

    case (state_q)
      S_FETCH: begin
        mem_req_raw = 1'b1;
        alusrcb     = SRCB_FOUR;
        if (bus.mem_ready) begin
          irwrite_raw = 1'b1;
          pcwrite     = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed here speculatively into ALUOut.
        alusrcb = SRCB_IMM_SH;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            illegal_raw = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_raw = 1'b1;
        iord        = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_raw  = 1'b1;
        memwrite_raw = 1'b1;
        iord         = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_FUNCT;
        illegal_raw = funct_illegal;
        state_d     = funct_illegal ? S_FETCH : S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // While reset is held the FSM sits in FETCH; gating with rst_n keeps the
  // memory request and every write strobe quiet until release.
  assign bus.mem_req    = mem_req_raw & rst_n;
  assign bus.memwrite   = memwrite_raw & rst_n;
  assign bus.irwrite    = irwrite_raw & rst_n;
  assign bus.pcen       = (pcwrite | (branch & bus.zero)) & rst_n;
  assign bus.illegal    = illegal_raw & rst_n;
  assign bus.regwrite   = regwrite;
  assign bus.iord       = iord;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alu_code;

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level reference model
// builds the expected state path and per-state control values.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  typedef struct packed {
    logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;
  } obs_t;

  typedef struct {
    state_e st;
    logic   rdy;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] state_w;
  int         checks = 0;
  int         errors = 0;
  step_t      path_q[$];

  multicycle_ctrl_if bus_if ();

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .state (state_w)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t o;
    o = {bus_if.mem_req, bus_if.memwrite, bus_if.iord, bus_if.irwrite, bus_if.pcen,
         bus_if.regwrite, bus_if.regdst, bus_if.memtoreg, bus_if.alusrca, bus_if.alusrcb,
         bus_if.pcsrc, bus_if.alucontrol, bus_if.illegal, state_w};
    return o;
  endfunction

  function automatic logic op_legal(input logic [5:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == ADDI) || (o == JMP);
  endfunction

  function automatic void funct_code(input logic [5:0] f, output logic [2:0] c, output logic ok);
    ok = 1'b1;
    c  = 3'b000;
    case (f)
      6'b100000: c = 3'b010;
      6'b100010: c = 3'b110;
      6'b100100: c = 3'b000;
      6'b100101: c = 3'b001;
      6'b101010: c = 3'b111;
      default:   ok = 1'b0;
    endcase
  endfunction

  // Expected controls for one cycle; m marks which fields the spec defines there.
  function automatic void model(input state_e st, input logic rdy, input logic zr,
                                input logic [5:0] o, input logic [5:0] f,
                                output obs_t e, output obs_t m);
    logic [2:0] code;
    logic       ok;
    e = '0;
    m = '0;
    m.mem_req = 1'b1; m.memwrite = 1'b1; m.irwrite = 1'b1; m.pcen = 1'b1;
    m.regwrite = 1'b1; m.illegal = 1'b1; m.state = 4'hf;
    e.state = st;
    case (st)
      S_FETCH: begin
        m.iord = 1'b1; m.alusrca = 1'b1; m.alusrcb = 2'b11; m.alucontrol = 3'b111; m.pcsrc = 2'b11;
        e.mem_req = 1'b1; e.alusrcb = 2'b01; e.alucontrol = 3'b010;
        e.irwrite = rdy; e.pcen = rdy;
      end
      S_DECODE: begin
        m.alusrca = 1'b1; m.alusrcb = 2'b11; m.alucontrol = 3'b111;
        e.alusrcb = 2'b11; e.alucontrol = 3'b010; e.illegal = !op_legal(o);
      end
      S_MEMADR, S_ADDIEX: begin
        m.alusrca = 1'b1; m.alusrcb = 2'b11; m.alucontrol = 3'b111;
        e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 3'b010;
      end
      S_MEMRD: begin
        m.iord = 1'b1; e.mem_req = 1'b1; e.iord = 1'b1;
      end
      S_MEMWR: begin
        m.iord = 1'b1; e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = 1'b1;
      end
      S_MEMWB, S_RTYPEWB, S_ADDIWB: begin
        m.regdst = 1'b1; m.memtoreg = 1'b1;
        e.regwrite = 1'b1;
        e.regdst   = (st == S_RTYPEWB);
        e.memtoreg = (st == S_MEMWB);
      end
      S_RTYPEEX: begin
        funct_code(f, code, ok);
        m.alusrca = 1'b1; m.alusrcb = 2'b11;
        e.alusrca = 1'b1; e.illegal = !ok;
        if (ok) begin
          m.alucontrol = 3'b111;
          e.alucontrol = code;
        end
      end
      S_BEQEX: begin
        m.alusrca = 1'b1; m.alusrcb = 2'b11; m.alucontrol = 3'b111; m.pcsrc = 2'b11;
        e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = zr;
      end
      S_JEX: begin
        m.pcsrc = 2'b11; e.pcsrc = 2'b10; e.pcen = 1'b1;
      end
      default: ;
    endcase
  endfunction

  function automatic step_t mk(input state_e st, input logic rdy);
    step_t s;
    s.st  = st;
    s.rdy = rdy;
    return s;
  endfunction

  // Expected state path of one instruction, from its class and the wait counts.
  task automatic build_path(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm);
    logic [2:0] code;
    logic       ok;
    path_q.delete();
    repeat (wf) path_q.push_back(mk(S_FETCH, 1'b0));
    path_q.push_back(mk(S_FETCH, 1'b1));
    path_q.push_back(mk(S_DECODE, 1'($urandom)));
    case (o)
      LW: begin
        path_q.push_back(mk(S_MEMADR, 1'($urandom)));
        repeat (wm) path_q.push_back(mk(S_MEMRD, 1'b0));
        path_q.push_back(mk(S_MEMRD, 1'b1));
        path_q.push_back(mk(S_MEMWB, 1'($urandom)));
      end
      SW: begin
        path_q.push_back(mk(S_MEMADR, 1'($urandom)));
        repeat (wm) path_q.push_back(mk(S_MEMWR, 1'b0));
        path_q.push_back(mk(S_MEMWR, 1'b1));
      end
      RT: begin
        funct_code(f, code, ok);
        path_q.push_back(mk(S_RTYPEEX, 1'($urandom)));
        if (ok) path_q.push_back(mk(S_RTYPEWB, 1'($urandom)));
      end
      BEQ: path_q.push_back(mk(S_BEQEX, 1'($urandom)));
      ADDI: begin
        path_q.push_back(mk(S_ADDIEX, 1'($urandom)));
        path_q.push_back(mk(S_ADDIWB, 1'($urandom)));
      end
      JMP: path_q.push_back(mk(S_JEX, 1'($urandom)));
      default: ;
    endcase
  endtask

  // Drives each path step on the falling edge and compares just after it.
  task automatic run_path(input string name, input logic [5:0] o, input logic [5:0] f, input logic zr);
    obs_t e, m, got;
    logic z;
    for (int i = 0; i < path_q.size(); i++) begin
      @(negedge clk);
      z = (path_q[i].st == S_BEQEX) ? zr : 1'($urandom);
      bus_if.mem_ready = path_q[i].rdy;
      bus_if.zero      = z;
      bus_if.op        = o;
      bus_if.funct     = f;
      #1;
      model(path_q[i].st, path_q[i].rdy, z, o, f, e, m);
      got = sample();
      checks++;
      if ((got & m) !== (e & m)) begin
        errors++;
        $display("FAIL %s cycle %0d (%s): got %h expected %h (mask %h)",
                 name, i, path_q[i].st.name(), got, e, m);
      end
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic zr, input int wf, input int wm);
    build_path(o, f, wf, wm);
    run_path(name, o, f, zr);
  endtask

  task automatic check_in_reset(input string name);
    obs_t e, m, got;
    model(S_FETCH, 1'b0, 1'b0, 6'd0, 6'd0, e, m);
    e.mem_req = 1'b0;
    m.iord = 1'b1; m.alusrca = 1'b1; m.alusrcb = 2'b11; m.alucontrol = 3'b111; m.pcsrc = 2'b11;
    got = sample();
    checks++;
    if ((got & m) !== (e & m)) begin
      errors++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, got, e, m);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.mem_ready = 1'b1;
    bus_if.zero = 1'b1;
    bus_if.op = JMP;
    bus_if.funct = 6'd0;
    #3;
    check_in_reset("reset_hold");
    @(posedge clk);
    #1;
    bus_if.mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_sw();
    path_q.delete();
    path_q.push_back(mk(S_FETCH, 1'b1));
    path_q.push_back(mk(S_DECODE, 1'b1));
    path_q.push_back(mk(S_MEMADR, 1'b1));
    path_q.push_back(mk(S_MEMWR, 1'b0));
    path_q.push_back(mk(S_MEMWR, 1'b0));
    run_path("sw_before_reset", SW, 6'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    bus_if.mem_ready = 1'b1;
    #1;
    check_in_reset("reset_in_memwr");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_if.mem_ready = 1'b0;
    run_instr("after_reset_add", RT, 6'b100000, 1'b0, 1, 0);
  endtask

  task automatic test_lw();
    run_instr("lw_zero_wait", LW, 6'd0, 1'b0, 0, 0);
    run_instr("lw_mem_wait", LW, 6'd0, 1'b0, 0, 2);
  endtask

  task automatic test_rtype();
    run_instr("rtype_slt", RT, 6'b101010, 1'b0, 0, 0);
    run_instr("rtype_sub", RT, 6'b100010, 1'b0, 0, 0);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", BEQ, 6'd0, 1'b1, 0, 0);
    run_instr("beq_not_taken", BEQ, 6'd0, 1'b0, 0, 0);
  endtask

  task automatic test_fetch_stall();
    run_instr("fetch_stall3", ADDI, 6'd0, 1'b0, 3, 0);
    run_instr("sw_stall", SW, 6'd0, 1'b0, 1, 2);
    run_instr("jump", JMP, 6'd0, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", 6'b111111, 6'd0, 1'b0, 0, 0);
    run_instr("illegal_funct", RT, 6'b000000, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [5:0] ops[6] = '{LW, SW, RT, BEQ, ADDI, JMP};
    logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] o, f;
    for (int n = 0; n < 60; n++) begin
      o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      f = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr("random", o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  task automatic test_idle();
    path_q.delete();
    path_q.push_back(mk(S_FETCH, 1'b0));
    path_q.push_back(mk(S_FETCH, 1'b0));
    run_path("idle_fetch", 6'b111111, 6'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_fetch_stall();
    test_illegal();
    test_reset_mid_sw();
    test_random();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control unit for the multicycle MIPS-subset datapath that shares one ALU and one unified memory across the fetch, decode, execute and writeback steps.
- Decodes op/funct and sequences PC, IR, register-file and memory enables over 3-5 cycles per instruction.
- Drives the 3-bit ALU control code: bit2 negates B, [1:0] selects 00 and / 01 or / 10 add / 11 slt.
- Stalls on a memory ready handshake. Flags illegal instructions and skips them.

Parameters:
- STATE_W, 4, width of the state register (12 states used).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  instr[31:26], valid from DECODE onward
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access requested
- memwrite  out  1  write strobe, qualified by mem_req
- iord  out  1  0 = PC address, 1 = ALUOut address
- irwrite  out  1  load IR
- pcen  out  1  PC load enable
- regwrite  out  1  register-file write
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = Data register, 0 = ALUOut
- alusrca  out  1  0 = PC, 1 = A
- alusrcb  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
- pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- alucontrol  out  3  ALU control code
- illegal  out  1  one-cycle pulse on an unsupported op/funct
- state  out  STATE_W  current state, for debug

Behaviour:
- Reset: state = FETCH asynchronously. All outputs take FETCH-state values while rst_n is low, except mem_req = 0 and illegal = 0. Reset mid-instruction abandons it: no pending regwrite/memwrite/pcen.
- Outputs are Moore, decoded from state. Exceptions: pcen = pcwrite | (branch & zero), and the memory-qualified strobes below.
- FETCH: mem_req = 1, iord = 0, alusrca = 0, alusrcb = 01, alucontrol = 010, pcsrc = 00. Waits while mem_ready = 0. irwrite and pcwrite are asserted only in the mem_ready = 1 cycle, which also moves to DECODE.
- DECODE: alusrca = 0, alusrcb = 11, alucontrol = 010 (branch target into ALUOut). Next state by op:
  - 100011 / 101011 -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - otherwise -> FETCH with illegal = 1 for this cycle
- MEMADR: alusrca = 1, alusrcb = 10, alucontrol = 010. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req = 1, iord = 1. Holds until mem_ready, then -> MEMWB.
- MEMWB: regwrite = 1, regdst = 0, memtoreg = 1 -> FETCH.
- MEMWR: mem_req = 1, iord = 1, memwrite = 1. Holds until mem_ready, then -> FETCH.
- RTYPEEX: alusrca = 1, alusrcb = 00, alucontrol from the funct decoder:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - Unsupported funct: illegal = 1 this cycle and next state FETCH (no writeback). Otherwise -> RTYPEWB.
- RTYPEWB: regwrite = 1, regdst = 1, memtoreg = 0 -> FETCH.
- BEQEX: alusrca = 1, alusrcb = 00, alucontrol = 110, pcsrc = 01, branch = 1. pcen = zero. -> FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, alucontrol = 010 -> ADDIWB.
- ADDIWB: regwrite = 1, regdst = 0, memtoreg = 0 -> FETCH.
- JEX: pcsrc = 10, pcwrite = 1 -> FETCH.
- Latency with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each mem_ready = 0 cycle adds one.
- Outside their states, regwrite, memwrite, irwrite and pcen are 0. mem_ready is ignored when mem_req = 0.
- Unused state encodings -> FETCH next cycle.

Decomposition:
- Shared header/package holds:
  - state encodings
  - opcode constants: LW, SW, RTYPE, BEQ, ADDI, J
  - funct constants
  - ALU codes: AND 000, OR 001, ADD 010, SUB 110, SLT 111
  - aluop codes: 00 add, 01 sub, 10 funct
- One sub-module, alu_decoder: combinational (aluop, funct) -> (alucontrol, funct_illegal). The FSM produces aluop.

Test Plan:
- Reset while in MEMWR with mem_ready = 0; release -> state = FETCH, memwrite = 0, regwrite = 0; first mem_ready = 1 gives irwrite = 1, pcen = 1.
- lw (op 100011), mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; regwrite = 1, memtoreg = 1, regdst = 0 only in cycle 5.
- R-type slt (funct 101010) -> alucontrol = 111 in RTYPEEX; regwrite = 1, regdst = 1 next cycle. Repeat with funct 100010 -> alucontrol = 110.
- beq with zero = 1 -> pcen = 1, pcsrc = 01 in BEQEX; with zero = 0 -> pcen = 0 throughout BEQEX.
- FETCH with mem_ready low for 3 cycles -> irwrite = 0 and pcen = 0 for those 3 cycles, mem_req = 1 held; irwrite and pcen go high on cycle 4.
- op 111111, then R-type funct 000000 -> illegal pulses one cycle each; next state FETCH; no regwrite or memwrite issued.
